div512_ss_rca: RTL
==================

# div512_ss_rca

Sequential shift-subtract (restoring) divider: the inverse of the 512-bit shift-add MAC datapath. It takes a 2·WIDTH-bit dividend (typically a MAC accumulator result) and a WIDTH-bit divisor and produces a WIDTH-bit quotient and remainder, one quotient bit per enabled cycle. Its subtract path is a ripple-carry adder. It sits downstream of the MAC array for normalisation and round-trip checking of products.

## Interface
- WIDTH, 256, divisor/quotient/remainder width; dividend is 2·WIDTH
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable; low freezes all state and outputs
- start  in  1  request; sampled only in IDLE with en=1
- dividend  in  2·WIDTH  numerator, unsigned
- divisor  in  WIDTH  denominator, unsigned
- quotient  out  WIDTH  result, registered
- remainder  out  WIDTH  result, registered
- busy  out  1  high from the accepting edge until done
- done  out  1  single-cycle completion pulse
- div_by_zero  out  1  sticky error flag for the last op, cleared on the next accept
- overflow  out  1  quotient does not fit (dividend[2W-1:W] ≥ divisor), cleared on the next accept

## Operation
- States: IDLE, RUN, DONE.
- Reset (async): state=IDLE, counter=0; all outputs and internal registers are 0.
- IDLE, en=1 and start=1: capture the operands; R = {1'b0, dividend[2W-1:W]} (W+1 bits) and Q = dividend[W-1:0]; clear both flags; assert busy.
  - If divisor==0: div_by_zero=1, go to DONE. Quotient and remainder are forced to all-ones and 0.
  - Else if dividend_hi ≥ divisor: overflow=1, go to DONE. Quotient and remainder are forced to all-ones and dividend_hi.
  - Else go to RUN with counter=0.
- RUN, each en=1 edge:
  - Shift {R,Q} left 1.
  - Compute trial = R_shifted − {1'b0,divisor} via the RCA, which adds the inverted divisor with cin=1.
  - If there is no borrow (cout=1): R=trial and Q[0]=1; else Q[0]=0.
  - counter++. After iteration WIDTH−1, go to DONE.
- DONE: quotient=Q, remainder=R[W-1:0], done=1, busy=0. The next en=1 edge returns to IDLE.
- start in RUN or DONE is ignored; there is no queueing.
- Results and flags hold until the next accepted start.
- Reset mid-RUN aborts the operation. Outputs return to 0, and there is no done pulse.

## Timing
- An accept edge at cycle 0 gives done high during cycle WIDTH+1 (i.e. after WIDTH+1 enabled edges), then low.
- Error paths: done is high in the cycle after the accept edge, giving 1-edge latency.
- en=0 stretches every phase 1:1. If done is high when en drops, it stays high until the first en=1 edge.
- start held high continuously: a new op is accepted in the IDLE cycle after done, giving a throughput of one op per WIDTH+2 cycles.
- The critical path is the single W+1-bit RCA ripple, accepted like the MAC's 512-bit RCA.

## Structure
- Package div_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the WIDTH default;
  - the counter width $clog2(WIDTH)+1.
- Sub-module: the existing RCA with .WIDTH(WIDTH+1) serves as subtractor. The overflow compare reuses a second RCA instance of width WIDTH, or the same one, muxed at accept.
- No other hierarchy.

## Test plan
- WIDTH=8: dividend 0x1234, divisor 0x56 -> quotient 0x36, remainder 0x10, done exactly 9 edges after the accept, no flags.
- WIDTH=8: 0xFEFF / 0xFF -> quotient 0xFF, remainder 0xFE. Also 0x5600 / 0x56 -> overflow=1, quotient 0xFF, remainder 0x56, done after 1 edge.
- WIDTH=8: divisor 0 -> div_by_zero=1, quotient 0xFF, remainder 0. A following valid op clears the flag.
- WIDTH=256 round trip: dividend = A·B from the MAC with random nonzero A, B; divisor A -> quotient B, remainder 0, done at edge 257.
- en toggled pseudo-randomly during RUN on a 0x1234/0x56 op -> same result, done after 9 enabled edges. start pulses during RUN are ignored.
- rst asserted mid-RUN -> all outputs 0 immediately (async), state IDLE, no done. The next start completes correctly.

Source files
------------

// File: rtl/div512_ss_rca_pkg.sv
// Shared constants for the shift-subtract divider: default width, counter
// sizing and the FSM state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 256;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div512_ss_rca_if.sv
// Request/result bundle of the divider. The master drives operands and the
// clock enable; the slave returns registered results, flags and its state.
interface div512_ss_rca_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);
  // Handshake: start is a request that is taken only on an en=1 edge while
  // state_dbg is IDLE (busy=0, done=0); at any other time it is ignored and
  // never queued. done is a one-cycle pulse; results and flags stay valid
  // until the next accepted request.
  logic                   en;
  logic                   start;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic [WIDTH-1:0]       quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   busy;
  logic                   done;
  logic                   div_by_zero;
  logic                   overflow;
  logic [1:0]             state_dbg;

  modport master (
    output en, start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow, state_dbg
  );

  modport slave (
    input  en, start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow, state_dbg
  );

endinterface

// File: rtl/div512_ss_rca_rca.sv
// Plain ripple-carry adder; used as a subtractor by feeding the inverted
// subtrahend with cin=1, so cout=1 means "no borrow".
module div512_ss_rca_rca #(
  parameter int WIDTH = 257
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
    end
    cout = c;
  end

endmodule

// File: rtl/div512_ss_rca.sv
// Restoring shift-subtract divider: 2W-bit dividend / W-bit divisor, one
// quotient bit per enabled cycle through a single (W+1)-bit ripple adder.
module div512_ss_rca
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic             clk,
  input logic             rst,
  div512_ss_rca_if.slave  bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  d_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  rem_q;
  logic              busy_q;
  logic              done_q;
  logic              dbz_q;
  logic              ovf_q;

  logic [WIDTH:0]    rca_a;
  logic [WIDTH:0]    rca_b;
  logic [WIDTH:0]    rca_sum;
  logic              rca_cout;
  logic              take;
  logic [WIDTH-1:0]  r_nxt;
  logic [WIDTH-1:0]  q_nxt;
  logic [WIDTH-1:0]  div_hi;

  assign div_hi = bus.dividend[2*WIDTH-1:WIDTH];

  // One adder serves both jobs: in IDLE it compares dividend_hi against the
  // divisor for overflow, in RUN it forms the trial subtraction.
  always_comb begin
    rca_a = '0;
    rca_b = '0;
    if (state == ST_IDLE) begin
      rca_a = {1'b0, div_hi};
      rca_b = ~{1'b0, bus.divisor};
    end else begin
      rca_a = {r_q, q_q[WIDTH-1]};
      rca_b = ~{1'b0, d_q};
    end
  end

  div512_ss_rca_rca #(
    .WIDTH (WIDTH + 1)
  ) u_rca (
    .a    (rca_a),
    .b    (rca_b),
    .cin  (1'b1),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // A successful subtract always leaves a W-bit result; the top sum bit is
  // folded in as a guard on that.
  assign take  = rca_cout & ~rca_sum[WIDTH];
  assign r_nxt = take ? rca_sum[WIDTH-1:0] : rca_a[WIDTH-1:0];
  assign q_nxt = {q_q[WIDTH-2:0], take};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.en) begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            d_q   <= bus.divisor;
            r_q   <= div_hi;
            q_q   <= bus.dividend[WIDTH-1:0];
            cnt   <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            if (bus.divisor == '0) begin
              dbz_q  <= 1'b1;
              quo_q  <= '1;
              rem_q  <= '0;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_DONE;
            end else if (take) begin
              ovf_q  <= 1'b1;
              quo_q  <= '1;
              rem_q  <= div_hi;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quo_q  <= q_nxt;
            rem_q  <= r_nxt;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign bus.state_dbg   = state;

endmodule
